// File: rtl/cosim_log_fetch_scheduler.sv
// cosim_log_fetch_scheduler: per-step Spike log fetch and item streaming; COSIM_LOG_OVERFLOW_FATAL_EN makes an over-long fetch fatal
package cosim_constants_pkg;
    localparam int DPI_W = 32;
    localparam int LOG_REG_WRITE_ITEM_DPI_WORDS = 3;
    localparam int LOG_MEM_ITEM_DPI_WORDS = 4;
endpackage

package cosim_log_dpi_pkg;
    import cosim_constants_pkg::*;
    localparam int LOG_CAP = 16;
    localparam int LOG_PROCS = 4;
    localparam int LOG_WORDS = (LOG_REG_WRITE_ITEM_DPI_WORDS > LOG_MEM_ITEM_DPI_WORDS) ?
                               LOG_REG_WRITE_ITEM_DPI_WORDS : LOG_MEM_ITEM_DPI_WORDS;
    localparam int LOG_ITEM_W = LOG_WORDS * DPI_W;
    typedef struct packed {
        logic [31:0] inserted;
        logic [LOG_CAP-1:0][LOG_ITEM_W-1:0] items;
    } log_fetch_t;
    logic [LOG_CAP-1:0][LOG_ITEM_W-1:0] log_items [3][LOG_PROCS];
    int unsigned log_count [3][LOG_PROCS];
    function automatic void log_clear();
        for (int k = 0; k < 3; k++)
            for (int p = 0; p < LOG_PROCS; p++) begin
                log_count[k][p] = 0;
                log_items[k][p] = '0;
            end
    endfunction
    function automatic void log_push(input logic [1:0] kind, input logic [1:0] processor_i,
                                     input logic [LOG_ITEM_W-1:0] item);
        if (log_count[kind][processor_i] < LOG_CAP)
            log_items[kind][processor_i][log_count[kind][processor_i][$clog2(LOG_CAP)-1:0]] = item;
        log_count[kind][processor_i]++;
    endfunction
    function automatic log_fetch_t fetch_log(input logic [1:0] kind, input logic [1:0] processor_i,
                                             input int words);
        log_fetch_t r;
        logic [LOG_ITEM_W-1:0] mask;
        r = '0;
        mask = '1;
        mask = mask >> (LOG_ITEM_W - words * DPI_W);
        r.inserted = log_count[kind][processor_i];
        for (int i = 0; i < LOG_CAP; i++)
            if (i < int'(r.inserted)) r.items[i] = log_items[kind][processor_i][i] & mask;
        return r;
    endfunction
    function automatic log_fetch_t private_get_log_reg_write(input logic [1:0] processor_i);
        return fetch_log(2'd0, processor_i, LOG_REG_WRITE_ITEM_DPI_WORDS);
    endfunction
    function automatic log_fetch_t private_get_log_mem_read(input logic [1:0] processor_i);
        return fetch_log(2'd1, processor_i, LOG_MEM_ITEM_DPI_WORDS);
    endfunction
    function automatic log_fetch_t private_get_log_mem_write(input logic [1:0] processor_i);
        return fetch_log(2'd2, processor_i, LOG_MEM_ITEM_DPI_WORDS);
    endfunction
endpackage

module cosim_log_fetch_scheduler
    import cosim_constants_pkg::*, cosim_log_dpi_pkg::*;
#(
    parameter int N_PROC = 1,
    parameter int MAX_ITEMS = 8,
    parameter int PROC_W = (N_PROC > 1) ? $clog2(N_PROC) : 1,
    parameter int ITEM_WORDS = (LOG_REG_WRITE_ITEM_DPI_WORDS > LOG_MEM_ITEM_DPI_WORDS) ?
                               LOG_REG_WRITE_ITEM_DPI_WORDS : LOG_MEM_ITEM_DPI_WORDS
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        item_valid_o,
    input  logic                        item_ready_i,
    output logic [1:0]                  item_kind_o,
    output logic [PROC_W-1:0]           item_proc_o,
    output logic                        item_last_o,
    output logic [ITEM_WORDS*DPI_W-1:0] item_data_o,
    output logic                        overflow_o
);
    localparam int ITEM_W = ITEM_WORDS * DPI_W;
    localparam int IDX_W = (MAX_ITEMS > 1) ? $clog2(MAX_ITEMS) : 1;
    localparam int CNT_W = $clog2(MAX_ITEMS + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t state_q, state_d;
    logic [PROC_W-1:0] proc_q, proc_d;
    logic [1:0] kind_q, kind_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, fetch_cnt;
    logic [ITEM_W-1:0] item_buf_q [MAX_ITEMS];
    logic [ITEM_W-1:0] fetch_items [MAX_ITEMS];
    logic [31:0] fetch_n;
    logic fetch_over, overflow_q, last_pair, advance;

    // Fetch of the current (processor, kind), latched at the edge that ends FETCH
    always_comb begin : fetch_comb
        log_fetch_t fr;
        fr = '0;
        if (state_q == FETCH && !rst_i)
            fr = (kind_q == 2'd0) ? private_get_log_reg_write(2'(proc_q)) :
                 (kind_q == 2'd1) ? private_get_log_mem_read(2'(proc_q)) :
                                    private_get_log_mem_write(2'(proc_q));
        fetch_n = fr.inserted;
        for (int i = 0; i < MAX_ITEMS; i++)
            fetch_items[i] = ITEM_W'(fr.items[i]);
    end

    assign fetch_over = fetch_n > 32'(MAX_ITEMS);
    assign fetch_cnt = fetch_over ? CNT_W'(MAX_ITEMS) : fetch_n[CNT_W-1:0];
    assign last_pair = (int'(proc_q) == N_PROC - 1) && (kind_q == 2'd2);
    assign advance = (state_q == FETCH && fetch_cnt == '0) ||
                     (item_valid_o && item_ready_i && item_last_o);

    // Next state and counters; an empty fetch or the last handshake moves to the next pair
    always_comb begin
        state_d = state_q;
        proc_d = proc_q;
        kind_d = kind_q;
        idx_d = idx_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = FETCH;
                proc_d = '0;
                kind_d = '0;
            end
            FETCH: begin
                state_d = DRAIN;
                idx_d = '0;
                cnt_d = fetch_cnt;
            end
            DRAIN: if (item_ready_i) idx_d = idx_q + 1'b1;
            default: state_d = IDLE;
        endcase
        if (advance) begin
            state_d = last_pair ? DONE : FETCH;
            kind_d = (kind_q == 2'd2) ? 2'd0 : kind_q + 2'd1;
            proc_d = last_pair ? '0 : (kind_q == 2'd2) ? proc_q + 1'b1 : proc_q;
        end
    end

    // State, counters and the sticky overflow flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            proc_q <= '0;
            kind_q <= '0;
            idx_q <= '0;
            cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            proc_q <= proc_d;
            kind_q <= kind_d;
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            if (state_q == FETCH && fetch_over) overflow_q <= 1'b1;
        end
    end

    // Item buffer loads at the end of FETCH; entries beyond cnt_q are never presented
    always_ff @(posedge clk_i) begin
        if (state_q == FETCH && !rst_i)
            for (int i = 0; i < MAX_ITEMS; i++) item_buf_q[i] <= fetch_items[i];
    end

`ifdef COSIM_LOG_OVERFLOW_FATAL_EN
    // Stop the simulation on a fetch that does not fit the buffer
    always_ff @(posedge clk_i) begin
        if (!rst_i && state_q == FETCH && fetch_over)
            $fatal(1, "cosim log overflow: proc %0d kind %0d count %0d", proc_q, kind_q, fetch_n);
    end
`else
    // Over-long fetches are clamped to MAX_ITEMS and reported through overflow_o only
`endif

    assign busy_o = state_q != IDLE;
    assign done_o = state_q == DONE;
    assign item_valid_o = state_q == DRAIN;
    assign item_last_o = item_valid_o && (CNT_W'(idx_q) == cnt_q - 1'b1);
    assign item_kind_o = item_valid_o ? kind_q : 2'd0;
    assign item_proc_o = item_valid_o ? proc_q : '0;
    assign item_data_o = item_valid_o ? item_buf_q[idx_q] : '0;
    assign overflow_o = overflow_q;
endmodule

// File: tb/tb_cosim_log_fetch_scheduler.sv
// tb_cosim_log_fetch_scheduler: table-driven check of the log fetch scheduler
module tb_cosim_log_fetch_scheduler;
    import cosim_log_dpi_pkg::*;

    localparam int W = 128;

    logic clk = 1'b0;
    logic rst = 1'b1, start_a = 1'b0, start_b = 1'b0, ready = 1'b0;
    logic busy_a, done_a, valid_a, last_a, ovf_a;
    logic busy_b, done_b, valid_b, last_b, ovf_b;
    logic [1:0] kind_a, kind_b;
    logic [0:0] proc_a, proc_b;
    logic [W-1:0] data_a, data_b;
    logic [7:0] ctl_a, ctl_b;
    int n_checks = 0, n_fail = 0;

    typedef struct {
        bit sel, rst, start, ready;
        logic [7:0] ctl;
        logic [W-1:0] data;
    } vec_t;
    vec_t vq[$];

    always #5 clk = ~clk;

    cosim_log_fetch_scheduler #(.N_PROC(1), .MAX_ITEMS(8)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
        .item_valid_o(valid_a), .item_ready_i(ready), .item_kind_o(kind_a), .item_proc_o(proc_a),
        .item_last_o(last_a), .item_data_o(data_a), .overflow_o(ovf_a));

    cosim_log_fetch_scheduler #(.N_PROC(2), .MAX_ITEMS(8)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
        .item_valid_o(valid_b), .item_ready_i(ready), .item_kind_o(kind_b), .item_proc_o(proc_b),
        .item_last_o(last_b), .item_data_o(data_b), .overflow_o(ovf_b));

    assign ctl_a = {busy_a, done_a, valid_a, kind_a, proc_a, last_a, ovf_a};
    assign ctl_b = {busy_b, done_b, valid_b, kind_b, proc_b, last_b, ovf_b};

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic void row(bit sel, bit rs, bit st, bit rd, bit busy, bit done, bit valid,
                                bit [1:0] kind, bit proc, bit last, bit ovf, logic [W-1:0] data);
        vq.push_back('{sel, rs, st, rd, {busy, done, valid, kind, proc, last, ovf}, data});
    endfunction

    function automatic logic [W-1:0] mem_item(int j);
        return {32'(32'h3000 + j), 32'(32'h2000 + j), 32'(32'h1000 + j), 32'(32'h100 + j)};
    endfunction

    function automatic logic [W-1:0] reg_exp(int j);
        return {32'h0, 32'(32'h30 + j), 32'(32'h20 + j), 32'(32'h10 + j)};
    endfunction

    function automatic logic [W-1:0] reg_raw(int j);
        return reg_exp(j) | {32'(32'hbad0 + j), 96'h0};
    endfunction

    // Each row: inputs driven this cycle and outputs expected during this cycle
    task automatic apply(input string tag);
        foreach (vq[i]) begin
            @(negedge clk);
            check($sformatf("%s c%0d ctl", tag, i), vq[i].sel ? W'(ctl_b) : W'(ctl_a), W'(vq[i].ctl));
            check($sformatf("%s c%0d data", tag, i), vq[i].sel ? data_b : data_a, vq[i].data);
            rst = vq[i].rst;
            start_a = vq[i].start && !vq[i].sel;
            start_b = vq[i].start && vq[i].sel;
            ready = vq[i].ready;
        end
        vq.delete();
    endtask

    initial begin
        int got;
        log_clear();
        repeat (2) @(negedge clk);
        check("reset ctl_a", W'(ctl_a), '0);
        check("reset data_a", data_a, '0);
        check("reset ctl_b", W'(ctl_b), '0);
        check("reset data_b", data_b, '0);
        rst = 1'b0;

        row(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, '0);
        for (int c = 1; c <= 3; c++) row(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, '0);
        row(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, '0);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
        apply("empty");

        log_push(2'd0, 2'd0, {32'h0, 32'h0, 32'hdead, 32'h5});
        row(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, '0);
        row(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, '0);
        row(0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 128'h0000dead_00000005);
        row(0, 0, 0, 1, 1, 0, 1, 0, 0, 1, 0, 128'h0000dead_00000005);
        row(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, '0);
        row(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, '0);
        row(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, '0);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
        apply("one_reg");

        log_clear();
        for (int j = 0; j < 3; j++) log_push(2'd2, 2'd1, mem_item(j));
        row(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, '0);
        for (int c = 1; c <= 6; c++) row(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, '0);
        row(1, 0, 0, 1, 1, 0, 1, 2, 1, 0, 0, mem_item(0));
        row(1, 0, 0, 0, 1, 0, 1, 2, 1, 0, 0, mem_item(1));
        row(1, 0, 0, 1, 1, 0, 1, 2, 1, 0, 0, mem_item(1));
        row(1, 0, 0, 0, 1, 0, 1, 2, 1, 1, 0, mem_item(2));
        row(1, 0, 0, 1, 1, 0, 1, 2, 1, 1, 0, mem_item(2));
        row(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, '0);
        row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
        apply("mem_wr_p1");

        log_clear();
        for (int j = 0; j < 10; j++) log_push(2'd0, 2'd0, reg_raw(j));
        check("ovf before", W'(ovf_a), '0);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && !done_a; c++) begin
            if (valid_a) begin
                check($sformatf("ovf item%0d data", got), data_a, reg_exp(got));
                check($sformatf("ovf item%0d last", got), W'(last_a), W'(got == 7));
                got++;
            end
            @(negedge clk);
        end
        check("ovf done seen", W'(done_a), W'(1));
        check("ovf item count", W'(got), W'(8));
        check("ovf flag", W'(ovf_a), W'(1));
        @(negedge clk);
        ready = 1'b0;
        check("ovf held idle", W'({busy_a, ovf_a}), W'(2'b01));

        log_clear();
        for (int j = 0; j < 4; j++) log_push(2'd0, 2'd0, reg_raw(j));
        row(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, '0);
        row(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, '0);
        row(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1, reg_exp(0));
        row(0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 1, reg_exp(1));
        row(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, '0);
        row(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, '0);
        for (int j = 0; j < 4; j++) row(0, 0, 0, 1, 1, 0, 1, 0, 0, j == 3, 0, reg_exp(j));
        row(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, '0);
        row(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, '0);
        row(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, '0);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
        apply("reset_mid");

        log_clear();
        for (int c = 0; c <= 3; c++) row(0, 0, 1, 0, c != 0, 0, 0, 0, 0, 0, 0, '0);
        row(0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, '0);
        row(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, '0);
        for (int c = 6; c <= 8; c++) row(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, '0);
        row(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, '0);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
        apply("start_held");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
